// File: rtl/memory_phase.sv
// Memory stage: turns execute results into data-memory requests and a registered
// write-back bundle, stalling upstream while a load or store is outstanding.
module memory_phase (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_result,
    input  logic [31:0] i_rs2_rdata,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rd_waddr,
    input  logic        i_rd_wen,
    output logic        o_dmem_req,
    output logic        o_dmem_wen,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_mask,
    input  logic        i_dmem_ready,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_stall,
    output logic        o_wb_valid,
    output logic [31:0] o_wb_data,
    output logic [4:0]  o_wb_rd,
    output logic        o_wb_wen,
    output logic        o_misaligned
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        req_q, req_d;
    logic        dwen_q, dwen_d;
    logic [31:0] daddr_q, daddr_d;
    logic [31:0] dwdata_q, dwdata_d;
    logic [3:0]  dmask_q, dmask_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic        load_q, load_d;
    logic [4:0]  rd_q, rd_d;
    logic        rdwen_q, rdwen_d;
    logic        wbv_q, wbv_d;
    logic [31:0] wbdata_q, wbdata_d;
    logic [4:0]  wbrd_q, wbrd_d;
    logic        wbwen_q, wbwen_d;
    logic        mis_q, mis_d;

    logic        is_mem;
    logic        misal;
    logic [31:0] st_data;
    logic [3:0]  st_mask;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign is_mem = i_mem_read | i_mem_write;

    // Size decode only looks at funct3[1:0]; the unsigned bit matters for loads only.
    always_comb begin
        misal   = 1'b0;
        st_data = i_rs2_rdata;
        st_mask = 4'b1111;
        case (i_funct3[1:0])
            2'b00: begin
                st_data = {4{i_rs2_rdata[7:0]}};
                st_mask = 4'b0001 << i_result[1:0];
            end
            2'b01: begin
                misal   = i_result[0];
                st_data = {2{i_rs2_rdata[15:0]}};
                st_mask = i_result[1] ? 4'b1100 : 4'b0011;
            end
            default: misal = |i_result[1:0];
        endcase
    end

    always_comb begin
        ld_byte = i_dmem_rdata[{off_q, 3'b000} +: 8];
        ld_half = off_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = i_dmem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        dwen_d   = dwen_q;
        daddr_d  = daddr_q;
        dwdata_d = dwdata_q;
        dmask_d  = dmask_q;
        off_d    = off_q;
        f3_d     = f3_q;
        load_d   = load_q;
        rd_d     = rd_q;
        rdwen_d  = rdwen_q;
        wbv_d    = 1'b0;
        wbdata_d = wbdata_q;
        wbrd_d   = wbrd_q;
        wbwen_d  = wbwen_q;
        mis_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    if (!is_mem) begin
                        wbv_d    = 1'b1;
                        wbdata_d = i_result;
                        wbrd_d   = i_rd_waddr;
                        wbwen_d  = i_rd_wen;
                    end else if (misal) begin
                        wbv_d    = 1'b1;
                        mis_d    = 1'b1;
                        wbdata_d = i_result;
                        wbrd_d   = i_rd_waddr;
                        wbwen_d  = 1'b0;
                    end else begin
                        // A read wins when both read and write are flagged.
                        state_d  = S_REQ;
                        req_d    = 1'b1;
                        dwen_d   = ~i_mem_read;
                        daddr_d  = {i_result[31:2], 2'b00};
                        dwdata_d = st_data;
                        dmask_d  = st_mask;
                        off_d    = i_result[1:0];
                        f3_d     = i_funct3;
                        load_d   = i_mem_read;
                        rd_d     = i_rd_waddr;
                        rdwen_d  = i_rd_wen;
                    end
                end
            end
            S_REQ: begin
                if (i_dmem_ready) begin
                    req_d  = 1'b0;
                    dwen_d = 1'b0;
                    if (load_q) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d  = S_IDLE;
                        wbv_d    = 1'b1;
                        wbdata_d = daddr_q;
                        wbrd_d   = rd_q;
                        wbwen_d  = 1'b0;
                    end
                end
            end
            S_WAIT: begin
                if (i_dmem_rvalid) begin
                    state_d  = S_IDLE;
                    wbv_d    = 1'b1;
                    wbdata_d = ld_data;
                    wbrd_d   = rd_q;
                    wbwen_d  = rdwen_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            dwen_q   <= 1'b0;
            daddr_q  <= 32'd0;
            dwdata_q <= 32'd0;
            dmask_q  <= 4'd0;
            off_q    <= 2'd0;
            f3_q     <= 3'd0;
            load_q   <= 1'b0;
            rd_q     <= 5'd0;
            rdwen_q  <= 1'b0;
            wbv_q    <= 1'b0;
            wbdata_q <= 32'd0;
            wbrd_q   <= 5'd0;
            wbwen_q  <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            dwen_q   <= dwen_d;
            daddr_q  <= daddr_d;
            dwdata_q <= dwdata_d;
            dmask_q  <= dmask_d;
            off_q    <= off_d;
            f3_q     <= f3_d;
            load_q   <= load_d;
            rd_q     <= rd_d;
            rdwen_q  <= rdwen_d;
            wbv_q    <= wbv_d;
            wbdata_q <= wbdata_d;
            wbrd_q   <= wbrd_d;
            wbwen_q  <= wbwen_d;
            mis_q    <= mis_d;
        end
    end

    assign o_stall      = (state_q != S_IDLE);
    assign o_dmem_req   = req_q;
    assign o_dmem_wen   = dwen_q;
    assign o_dmem_addr  = daddr_q;
    assign o_dmem_wdata = dwdata_q;
    assign o_dmem_mask  = dmask_q;
    assign o_wb_valid   = wbv_q;
    assign o_wb_data    = wbdata_q;
    assign o_wb_rd      = wbrd_q;
    assign o_wb_wen     = wbwen_q;
    assign o_misaligned = mis_q;
endmodule

// File: tb/tb_memory_phase.sv
// Bench for memory_phase: a vector table drives ops through a small memory responder,
// expected write-backs are queued at issue and checked when o_wb_valid fires.
module tb_memory_phase;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [31:0] i_result;
    logic [31:0] i_rs2_rdata;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [2:0]  i_funct3;
    logic [4:0]  i_rd_waddr;
    logic        i_rd_wen;
    logic        o_dmem_req;
    logic        o_dmem_wen;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_mask;
    logic        i_dmem_ready;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    logic        o_stall;
    logic        o_wb_valid;
    logic [31:0] o_wb_data;
    logic [4:0]  o_wb_rd;
    logic        o_wb_wen;
    logic        o_misaligned;

    memory_phase dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_result(i_result),
        .i_rs2_rdata(i_rs2_rdata), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_funct3(i_funct3), .i_rd_waddr(i_rd_waddr), .i_rd_wen(i_rd_wen),
        .o_dmem_req(o_dmem_req), .o_dmem_wen(o_dmem_wen), .o_dmem_addr(o_dmem_addr),
        .o_dmem_wdata(o_dmem_wdata), .o_dmem_mask(o_dmem_mask),
        .i_dmem_ready(i_dmem_ready), .i_dmem_rvalid(i_dmem_rvalid),
        .i_dmem_rdata(i_dmem_rdata), .o_stall(o_stall), .o_wb_valid(o_wb_valid),
        .o_wb_data(o_wb_data), .o_wb_rd(o_wb_rd), .o_wb_wen(o_wb_wen),
        .o_misaligned(o_misaligned)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        rd_op;
        logic        wr_op;
        logic [2:0]  f3;
        logic [31:0] res;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        rwen;
        int          dly;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_mask;
        logic        e_dwen;
        logic        e_mis;
        logic [31:0] e_data;
        logic        e_wen;
        logic        chk_data;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wen;
        logic        mis;
        logic        chk_data;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    vec_t vt[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                                input logic [31:0] res, input logic [31:0] rs2,
                                input logic [4:0] rd, input logic rwen, input int dly,
                                input logic [31:0] rdata, input logic [31:0] e_addr,
                                input logic [31:0] e_wdata, input logic [3:0] e_mask,
                                input logic e_dwen, input logic e_mis,
                                input logic [31:0] e_data, input logic e_wen,
                                input logic chk_data);
        vec_t v;
        v.rd_op = rd_op; v.wr_op = wr_op; v.f3 = f3; v.res = res; v.rs2 = rs2;
        v.rd = rd; v.rwen = rwen; v.dly = dly; v.rdata = rdata; v.e_addr = e_addr;
        v.e_wdata = e_wdata; v.e_mask = e_mask; v.e_dwen = e_dwen; v.e_mis = e_mis;
        v.e_data = e_data; v.e_wen = e_wen; v.chk_data = chk_data;
        return v;
    endfunction

    // Write-back monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge i_clk) begin
        if (!i_rst && o_wb_valid) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", {31'd0, o_wb_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_wen", {31'd0, o_wb_wen}, {31'd0, e.wen});
                chk("wb_misaligned", {31'd0, o_misaligned}, {31'd0, e.mis});
                if (e.chk_data) begin
                    chk("wb_data", o_wb_data, e.data);
                    chk("wb_rd", {27'd0, o_wb_rd}, {27'd0, e.rd});
                end
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_op(input vec_t v, input int idx);
        exp_t e;
        int   stalls;
        logic is_mem;
        is_mem        = v.rd_op | v.wr_op;
        i_valid       = 1'b1;
        i_result      = v.res;
        i_rs2_rdata   = v.rs2;
        i_mem_read    = v.rd_op;
        i_mem_write   = v.wr_op;
        i_funct3      = v.f3;
        i_rd_waddr    = v.rd;
        i_rd_wen      = v.rwen;
        e.data = v.e_data; e.rd = v.rd; e.wen = v.e_wen; e.mis = v.e_mis;
        e.chk_data = v.chk_data;
        sb.push_back(e);
        step();
        i_valid     = 1'b0;
        i_mem_read  = 1'b0;
        i_mem_write = 1'b0;
        if (v.e_mis || !is_mem) begin
            chk($sformatf("v%0d_wb_now", idx), {31'd0, o_wb_valid}, 32'd1);
            chk($sformatf("v%0d_mis_now", idx), {31'd0, o_misaligned}, {31'd0, v.e_mis});
            chk($sformatf("v%0d_req_off", idx), {31'd0, o_dmem_req}, 32'd0);
            chk($sformatf("v%0d_stall_off", idx), {31'd0, o_stall}, 32'd0);
        end else begin
            stalls = 0;
            for (int c = 0; c <= v.dly; c++) begin
                if (o_stall) stalls++;
                chk($sformatf("v%0d_req", idx), {31'd0, o_dmem_req}, 32'd1);
                chk($sformatf("v%0d_addr", idx), o_dmem_addr, v.e_addr);
                chk($sformatf("v%0d_mask", idx), {28'd0, o_dmem_mask}, {28'd0, v.e_mask});
                chk($sformatf("v%0d_dwen", idx), {31'd0, o_dmem_wen}, {31'd0, v.e_dwen});
                if (v.e_dwen) chk($sformatf("v%0d_wdata", idx), o_dmem_wdata, v.e_wdata);
                if (c == v.dly) i_dmem_ready = 1'b1;
                step();
            end
            i_dmem_ready = 1'b0;
            if (v.rd_op) begin
                if (o_stall) stalls++;
                chk($sformatf("v%0d_req_wait", idx), {31'd0, o_dmem_req}, 32'd0);
                i_dmem_rvalid = 1'b1;
                i_dmem_rdata  = v.rdata;
                step();
                i_dmem_rvalid = 1'b0;
                i_dmem_rdata  = 32'hDEAD_0000;
            end
            chk($sformatf("v%0d_stall_cycles", idx), stalls, v.dly + 1 + (v.rd_op ? 1 : 0));
            chk($sformatf("v%0d_wb_lat", idx), {31'd0, o_wb_valid}, 32'd1);
            chk($sformatf("v%0d_stall_done", idx), {31'd0, o_stall}, 32'd0);
        end
    endtask

    initial begin
        //           rd wr f3      res           rs2           rd  wen dly rdata         e_addr        e_wdata       mask     dwen mis e_data        e_wen chk
        vt[0]  = mk(0, 0, 3'b010, 32'h0000_1234, 32'h0,        5,  1,  0,  32'h0,        32'h0,        32'h0,        4'b0000, 0,   0,  32'h0000_1234, 1,   1);
        vt[1]  = mk(0, 0, 3'b000, 32'hDEAD_BEEF, 32'h0,        31, 0,  0,  32'h0,        32'h0,        32'h0,        4'b0000, 0,   0,  32'hDEAD_BEEF, 0,   1);
        vt[2]  = mk(1, 0, 3'b000, 32'h0000_0103, 32'h0,        7,  1,  0,  32'h80FF_FFFF, 32'h0000_0100, 32'h0,       4'b1000, 0,   0,  32'hFFFF_FF80, 1,   1);
        vt[3]  = mk(1, 0, 3'b100, 32'h0000_0103, 32'h0,        7,  1,  0,  32'h80FF_FFFF, 32'h0000_0100, 32'h0,       4'b1000, 0,   0,  32'h0000_0080, 1,   1);
        vt[4]  = mk(1, 0, 3'b001, 32'h0000_0202, 32'h0,        3,  1,  1,  32'h8001_7FFF, 32'h0000_0200, 32'h0,       4'b1100, 0,   0,  32'hFFFF_8001, 1,   1);
        vt[5]  = mk(1, 0, 3'b101, 32'h0000_0200, 32'h0,        6,  1,  0,  32'h8001_F00D, 32'h0000_0200, 32'h0,       4'b0011, 0,   0,  32'h0000_F00D, 1,   1);
        vt[6]  = mk(1, 0, 3'b010, 32'h0000_0300, 32'h0,        8,  1,  2,  32'hCAFE_BABE, 32'h0000_0300, 32'h0,       4'b1111, 0,   0,  32'hCAFE_BABE, 1,   1);
        vt[7]  = mk(0, 1, 3'b001, 32'h0000_0102, 32'hABCD_1234, 9, 1,  3,  32'h0,        32'h0000_0100, 32'h1234_1234, 4'b1100, 1,   0,  32'h0,        0,   0);
        vt[8]  = mk(0, 1, 3'b000, 32'h0000_0401, 32'h0000_00A5, 2, 0,  0,  32'h0,        32'h0000_0400, 32'hA5A5_A5A5, 4'b0010, 1,   0,  32'h0,        0,   0);
        vt[9]  = mk(0, 1, 3'b010, 32'h0000_0504, 32'h1122_3344, 2, 0,  1,  32'h0,        32'h0000_0504, 32'h1122_3344, 4'b1111, 1,   0,  32'h0,        0,   0);
        vt[10] = mk(1, 0, 3'b010, 32'h0000_0101, 32'h0,        4,  1,  0,  32'h0,        32'h0,        32'h0,        4'b0000, 0,   1,  32'h0,        0,   0);
        vt[11] = mk(0, 1, 3'b001, 32'h0000_0203, 32'h0000_FFFF, 4, 1, 0,  32'h0,        32'h0,        32'h0,        4'b0000, 0,   1,  32'h0,        0,   0);
        vt[12] = mk(1, 1, 3'b000, 32'h0000_0000, 32'h0000_0055, 12, 1, 0, 32'h1234_5678, 32'h0000_0000, 32'h5555_5555, 4'b0001, 0,  0,  32'h0000_0078, 1,   1);

        i_rst = 1'b1; i_valid = 1'b0; i_result = 32'h0; i_rs2_rdata = 32'h0;
        i_mem_read = 1'b0; i_mem_write = 1'b0; i_funct3 = 3'b0; i_rd_waddr = 5'd0;
        i_rd_wen = 1'b0; i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'h0;
        repeat (3) step();
        chk("rst_stall", {31'd0, o_stall}, 32'd0);
        chk("rst_req", {31'd0, o_dmem_req}, 32'd0);
        chk("rst_dwen", {31'd0, o_dmem_wen}, 32'd0);
        chk("rst_addr", o_dmem_addr, 32'd0);
        chk("rst_mask", {28'd0, o_dmem_mask}, 32'd0);
        chk("rst_wb_valid", {31'd0, o_wb_valid}, 32'd0);
        chk("rst_wb_data", o_wb_data, 32'd0);
        chk("rst_mis", {31'd0, o_misaligned}, 32'd0);
        i_rst = 1'b0;
        step();

        for (int i = 0; i < 13; i++) run_op(vt[i], i);

        // Stray handshakes while idle must be ignored.
        step();
        i_dmem_ready = 1'b1; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hFFFF_FFFF;
        step();
        step();
        chk("stray_stall", {31'd0, o_stall}, 32'd0);
        chk("stray_wb", {31'd0, o_wb_valid}, 32'd0);
        chk("stray_req", {31'd0, o_dmem_req}, 32'd0);
        i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0;

        // Reset while a load waits for data, followed by a late rvalid.
        i_valid = 1'b1; i_mem_read = 1'b1; i_funct3 = 3'b010; i_result = 32'h0000_0600;
        i_rd_waddr = 5'd11; i_rd_wen = 1'b1;
        step();
        i_valid = 1'b0; i_mem_read = 1'b0;
        i_dmem_ready = 1'b1;
        step();
        i_dmem_ready = 1'b0;
        chk("rstw_in_wait", {31'd0, o_stall}, 32'd1);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("rstw_stall", {31'd0, o_stall}, 32'd0);
        chk("rstw_req", {31'd0, o_dmem_req}, 32'd0);
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h1357_9BDF;
        step();
        i_dmem_rvalid = 1'b0;
        chk("rstw_wb", {31'd0, o_wb_valid}, 32'd0);
        chk("rstw_stall2", {31'd0, o_stall}, 32'd0);
        step();
        chk("rstw_wb2", {31'd0, o_wb_valid}, 32'd0);

        for (int k = 0; k < 20 && sb.size() != 0; k++) step();
        chk("sb_drain", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
